ora_misr: RTL and testbench
===========================

ORA_MISR -- requirements
Module: ora_misr

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each circuit-output bus.
REQ-002 Parameter SIG_WIDTH, default 16: MISR signature width; SHALL be >= WIDTH.
REQ-003 Parameter POLY, default 16'h1021: MISR feedback polynomial, SIG_WIDTH bits.
REQ-004 Parameter SEED, default 0: MISR initial value, SIG_WIDTH bits.
REQ-005 Parameter CNT_WIDTH, default 8: width of the pattern counter.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  begins a test session; sampled only in IDLE.
REQ-009 num_patterns  in  CNT_WIDTH  number of valid patterns in the session; sampled with start.
REQ-010 valid  in  1  cut_op and ff_op carry a pattern response this cycle.
REQ-011 cut_op  in  WIDTH  output of the circuit under test.
REQ-012 ff_op  in  WIDTH  fault-free reference output.
REQ-013 busy  out  1  high in RUN and CHECK.
REQ-014 done  out  1  single-cycle pulse at session end.
REQ-015 pass  out  1  session verdict; valid from the done cycle until the next start.
REQ-016 sig_cut, sig_ff  out  SIG_WIDTH each  current MISR signatures.
REQ-017 mismatch_seen  out  1  sticky flag: some pattern had cut_op != ff_op.
REQ-018 first_fail_idx  out  CNT_WIDTH  index (0-based) of the first mismatching pattern.

Function
REQ-019 FSM states IDLE, RUN, CHECK, DONE; encoding is free.
REQ-020 IDLE: start=1 with num_patterns>0 -> RUN; with num_patterns=0 -> CHECK; loads count=0, sig_cut=sig_ff=SEED, clears mismatch_seen, first_fail_idx and pass.
REQ-021 RUN, valid=1: each MISR updates as sig <= {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ zero-extended input; count increments.
REQ-022 RUN, valid=0: MISRs, count and flags hold.
REQ-023 RUN, valid=1 and cut_op != ff_op and mismatch_seen=0: mismatch_seen <= 1, first_fail_idx <= count; later mismatches do not change first_fail_idx.
REQ-024 RUN, valid=1 and count == num_patterns-1: that pattern is compacted, then -> CHECK.
REQ-025 CHECK (one cycle): pass <= (sig_cut == sig_ff) and not mismatch_seen; -> DONE.
REQ-026 DONE (one cycle): done=1, busy=0; -> IDLE.
REQ-027 valid outside RUN SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-028 Count SHALL NOT wrap: the session ends exactly at num_patterns patterns (max 2^CNT_WIDTH-1).
REQ-029 Signatures, pass, mismatch_seen and first_fail_idx SHALL hold their values in IDLE until the next accepted start.
REQ-030 Latency: done asserts exactly 2 cycles after the edge accepting the last valid pattern.

Reset
REQ-031 rst=1 at a rising edge, in any state including mid-session: state <= IDLE; busy=0, done=0, pass=0, mismatch_seen=0, first_fail_idx=0, sig_cut=sig_ff=SEED, count=0.
REQ-032 rst SHALL take priority over start and valid in the same cycle.

Verification
REQ-033 Defaults; start, num_patterns=4, 4 valid cycles with cut_op=ff_op={1,2,3,4} -> done 2 cycles after last, pass=1, sig_cut==sig_ff, mismatch_seen=0.
REQ-034 Same stimulus but cut_op=4'hF on pattern 2 only -> mismatch_seen=1, first_fail_idx=2, pass=0; mismatch on patterns 1 and 3 -> first_fail_idx=1.
REQ-035 num_patterns=3 with valid gaps (valid low 2 cycles between patterns) -> MISRs unchanged during gaps, done after 3rd valid, same signatures as gapless run.
REQ-036 num_patterns=0 -> CHECK then DONE: done 2 cycles after start, pass=1, sig_cut=sig_ff=SEED.
REQ-037 rst asserted after 2 of 5 patterns -> next cycle IDLE, busy=0, all outputs at reset values; new start runs a clean session to pass=1.
REQ-038 start pulsed during RUN and valid during IDLE/DONE -> no effect on count, signatures or verdict.

Source files
------------

// File: rtl/ora_misr.sv
`default_nettype none
// ============================================================================
// Module      : ora_misr
// Description : Output response analyser. It compacts the outputs of the
//               circuit under test and the fault-free reference into two
//               MISR signatures. It also tracks the first mismatching
//               pattern and gives a pass/fail verdict at the end of each
//               session.
// Revision    : 1.0 - initial release
// ============================================================================
module ora_misr #(
    parameter int                   WIDTH     = 4,
    parameter int                   SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] POLY      = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SEED      = '0,
    parameter int                   CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_patterns,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     cut_op,
    input  logic [WIDTH-1:0]     ff_op,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] sig_cut,
    output logic [SIG_WIDTH-1:0] sig_ff,
    output logic                 mismatch_seen,
    output logic [CNT_WIDTH-1:0] first_fail_idx
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_check = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_num;
    logic [SIG_WIDTH-1:0] r_sig_cut;
    logic [SIG_WIDTH-1:0] r_sig_ff;
    logic                 r_mismatch;
    logic [CNT_WIDTH-1:0] r_first_idx;
    logic                 r_pass;

    logic                 w_last;
    logic                 w_accept;
    logic [SIG_WIDTH-1:0] w_sig_cut_next;
    logic [SIG_WIDTH-1:0] w_sig_ff_next;

    // A pattern is compacted only when it arrives during RUN
    assign w_accept = (r_state == c_st_run) && valid;
    // r_num is never zero in RUN, so num-1 cannot underflow here
    assign w_last   = (r_count == (r_num - c_cnt_one));

    // Galois-style MISR step: shift, conditional polynomial feedback,
    // then fold in the zero-extended response word
    assign w_sig_cut_next = {r_sig_cut[SIG_WIDTH-2:0], 1'b0}
                          ^ (r_sig_cut[SIG_WIDTH-1] ? POLY : '0)
                          ^ SIG_WIDTH'(cut_op);
    assign w_sig_ff_next  = {r_sig_ff[SIG_WIDTH-2:0], 1'b0}
                          ^ (r_sig_ff[SIG_WIDTH-1] ? POLY : '0)
                          ^ SIG_WIDTH'(ff_op);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an empty session skips RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = (num_patterns != '0) ? c_st_run : c_st_check;
                end
            end
            c_st_run: begin
                if (valid && w_last) begin
                    w_state_next = c_st_check;
                end
            end
            c_st_check: w_state_next = c_st_done;
            c_st_done:  w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // Session datapath: load on start, compact in RUN, decide in CHECK
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_num       <= '0;
            r_sig_cut   <= SEED;
            r_sig_ff    <= SEED;
            r_mismatch  <= 1'b0;
            r_first_idx <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_count     <= '0;
                        r_num       <= num_patterns;
                        r_sig_cut   <= SEED;
                        r_sig_ff    <= SEED;
                        r_mismatch  <= 1'b0;
                        r_first_idx <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                c_st_run: begin
                    if (w_accept) begin
                        r_sig_cut <= w_sig_cut_next;
                        r_sig_ff  <= w_sig_ff_next;
                        // Ends at r_num, which fits the counter, so no wrap
                        r_count   <= r_count + c_cnt_one;
                        if ((cut_op != ff_op) && !r_mismatch) begin
                            r_mismatch  <= 1'b1;
                            r_first_idx <= r_count;
                        end
                    end
                end
                c_st_check: begin
                    r_pass <= (r_sig_cut == r_sig_ff) && !r_mismatch;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy           = (r_state == c_st_run) || (r_state == c_st_check);
    assign done           = (r_state == c_st_done);
    assign pass           = r_pass;
    assign sig_cut        = r_sig_cut;
    assign sig_ff         = r_sig_ff;
    assign mismatch_seen  = r_mismatch;
    assign first_fail_idx = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_ora_misr.sv
`default_nettype none
// ============================================================================
// Module      : tb_ora_misr
// Description : Self-checking bench for ora_misr. Each session's expected
//               verdict and signatures are queued when the stimulus is driven.
//               They are popped and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ora_misr;

    localparam int          WIDTH     = 4;
    localparam int          SIG_WIDTH = 16;
    localparam int          CNT_WIDTH = 8;
    localparam logic [15:0] POLY      = 16'h1021;
    localparam logic [15:0] SEED      = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_patterns;
    logic        valid;
    logic [3:0]  cut_op;
    logic [3:0]  ff_op;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig_cut;
    logic [15:0] sig_ff;
    logic        mismatch_seen;
    logic [7:0]  first_fail_idx;

    typedef struct packed {
        logic        pass;
        logic [15:0] sc;
        logic [15:0] sf;
        logic        mm;
        logic [7:0]  idx;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  cut_v[8];
    logic [3:0]  ff_v[8];
    int          n_pat;
    int          gap;
    bit          poke;
    logic [15:0] last_sc;
    logic [15:0] last_sf;

    ora_misr #(
        .WIDTH    (WIDTH),
        .SIG_WIDTH(SIG_WIDTH),
        .POLY     (POLY),
        .SEED     (SEED),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_patterns  (num_patterns),
        .valid         (valid),
        .cut_op        (cut_op),
        .ff_op         (ff_op),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .sig_cut       (sig_cut),
        .sig_ff        (sig_ff),
        .mismatch_seen (mismatch_seen),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    // Reference MISR step written directly from the update equation
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {12'h000, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] c, input logic [15:0] f, input int n);
        for (int i = 0; i < 4; i++) begin
            cut_v[i] = c[i*4 +: 4];
            ff_v[i]  = f[i*4 +: 4];
        end
        n_pat = n;
    endtask

    // Runs one full session from IDLE and checks every phase timing-exactly
    task automatic run_session(input string tag);
        exp_t        e;
        logic [15:0] sc;
        logic [15:0] sf;
        bit          mm;
        int          idx;
        sc = SEED; sf = SEED; mm = 1'b0; idx = 0;
        start = 1'b1; num_patterns = CNT_WIDTH'(n_pat); valid = 1'b0;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b exp 1", tag, busy);
        end
        for (int i = 0; i < n_pat; i++) begin
            valid = 1'b1; cut_op = cut_v[i]; ff_op = ff_v[i];
            if (poke && i == 0) begin
                start = 1'b1; num_patterns = 8'd1;
            end
            sc = misr_step(sc, cut_v[i]);
            sf = misr_step(sf, ff_v[i]);
            if (cut_v[i] != ff_v[i] && !mm) begin
                mm = 1'b1; idx = i;
            end
            step();
            valid = 1'b0; start = 1'b0;
            if (i < n_pat - 1) begin
                for (int g = 0; g < gap; g++) begin
                    cut_op = 4'hA; ff_op = 4'h5;
                    step();
                    checks++;
                    if (sig_cut !== sc || sig_ff !== sf) begin
                        errors++;
                        $display("FAIL %s gap_hold: got %h/%h exp %h/%h", tag, sig_cut, sig_ff, sc, sf);
                    end
                end
            end
        end
        e.pass = (sc == sf) && !mm;
        e.sc = sc; e.sf = sf; e.mm = mm; e.idx = 8'(idx);
        sb_q.push_back(e);
        // CHECK cycle
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s check_phase: got done=%b busy=%b exp 0/1", tag, done, busy);
        end
        step();
        // DONE cycle
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s done_phase: got done=%b busy=%b exp 1/0", tag, done, busy);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("FAIL %s scoreboard: got empty queue exp 1 entry", tag);
        end else begin
            e = sb_q.pop_front();
            if (pass !== e.pass || sig_cut !== e.sc || sig_ff !== e.sf ||
                mismatch_seen !== e.mm || first_fail_idx !== e.idx) begin
                errors++;
                $display("FAIL %s verdict: got p=%b %h/%h mm=%b idx=%0d exp p=%b %h/%h mm=%b idx=%0d",
                         tag, pass, sig_cut, sig_ff, mismatch_seen, first_fail_idx,
                         e.pass, e.sc, e.sf, e.mm, e.idx);
            end
        end
        if (poke) begin
            valid = 1'b1; cut_op = 4'hF; ff_op = 4'h0;
        end
        step();
        valid = 1'b0;
        // Back in IDLE: everything must hold
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== e.pass || sig_cut !== e.sc ||
            sig_ff !== e.sf || mismatch_seen !== e.mm || first_fail_idx !== e.idx) begin
            errors++;
            $display("FAIL %s idle_hold: got d=%b b=%b p=%b %h/%h mm=%b idx=%0d", tag,
                     done, busy, pass, sig_cut, sig_ff, mismatch_seen, first_fail_idx);
        end
        last_sc = sig_cut; last_sf = sig_ff;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || mismatch_seen !== 1'b0 ||
            first_fail_idx !== 8'd0 || sig_cut !== SEED || sig_ff !== SEED) begin
            errors++;
            $display("FAIL reset_state: got b=%b d=%b p=%b mm=%b idx=%0d %h/%h exp all zero/SEED",
                     busy, done, pass, mismatch_seen, first_fail_idx, sig_cut, sig_ff);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_clean();
        gap = 0; poke = 1'b0;
        load(16'h4321, 16'h4321, 4);
        run_session("clean");
    endtask

    task automatic test_mismatch();
        gap = 0; poke = 1'b0;
        load(16'h4F21, 16'h4321, 4);
        run_session("mismatch_p2");
        load(16'hF3F1, 16'h4321, 4);
        run_session("mismatch_p1p3");
    endtask

    task automatic test_gaps();
        logic [15:0] ref_sc;
        logic [15:0] ref_sf;
        poke = 1'b0;
        gap = 0;
        load(16'h0321, 16'h0321, 3);
        run_session("gapless");
        ref_sc = last_sc; ref_sf = last_sf;
        gap = 2;
        run_session("gapped");
        checks++;
        if (last_sc !== ref_sc || last_sf !== ref_sf) begin
            errors++;
            $display("FAIL gap_vs_gapless: got %h/%h exp %h/%h", last_sc, last_sf, ref_sc, ref_sf);
        end
        gap = 0;
    endtask

    task automatic test_zero();
        gap = 0; poke = 1'b0;
        n_pat = 0;
        run_session("zero_patterns");
    endtask

    task automatic test_mid_reset();
        start = 1'b1; num_patterns = 8'd5;
        step();
        start = 1'b0;
        valid = 1'b1; cut_op = 4'hF; ff_op = 4'h1;
        step();
        cut_op = 4'h2; ff_op = 4'h2;
        step();
        // reset together with start and valid: reset must win
        rst = 1'b1; start = 1'b1; num_patterns = 8'd3; valid = 1'b1; cut_op = 4'hF; ff_op = 4'h0;
        step();
        rst = 1'b0; start = 1'b0; valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || mismatch_seen !== 1'b0 ||
            first_fail_idx !== 8'd0 || sig_cut !== SEED || sig_ff !== SEED) begin
            errors++;
            $display("FAIL mid_reset: got b=%b d=%b p=%b mm=%b idx=%0d %h/%h exp reset values",
                     busy, done, pass, mismatch_seen, first_fail_idx, sig_cut, sig_ff);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle: got busy=%b exp 0", busy);
        end
        gap = 0; poke = 1'b0;
        load(16'h8765, 16'h8765, 4);
        run_session("after_reset");
    endtask

    task automatic test_ignored();
        logic [15:0] hold_sc;
        logic [15:0] hold_sf;
        hold_sc = sig_cut; hold_sf = sig_ff;
        valid = 1'b1; cut_op = 4'hF; ff_op = 4'h0;
        step();
        step();
        valid = 1'b0;
        checks++;
        if (sig_cut !== hold_sc || sig_ff !== hold_sf || mismatch_seen !== 1'b0 ||
            pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: got %h/%h mm=%b p=%b b=%b exp %h/%h 0 1 0",
                     sig_cut, sig_ff, mismatch_seen, pass, busy, hold_sc, hold_sf);
        end
        gap = 0; poke = 1'b1;
        load(16'h9ABC, 16'h9ABC, 4);
        run_session("ignored_start_valid");
        poke = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_patterns = '0; valid = 1'b0; cut_op = '0; ff_op = '0;
        gap = 0; poke = 1'b0; n_pat = 0; last_sc = '0; last_sf = '0;
        test_reset();
        test_clean();
        test_mismatch();
        test_gaps();
        test_zero();
        test_mid_reset();
        test_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
